// File: rtl/fx_ad_fifo_pkg.sv
// Shared FX-bus definitions: register offsets and STATUS/CTRL bit positions.
package fx_ad_fifo_pkg;

    localparam logic [3:0] FX_REG_CTRL   = 4'h0;
    localparam logic [3:0] FX_REG_STATUS = 4'h1;
    localparam logic [3:0] FX_REG_CNT_L  = 4'h2;
    localparam logic [3:0] FX_REG_CNT_H  = 4'h3;
    localparam logic [3:0] FX_REG_DATA_L = 4'h4;
    localparam logic [3:0] FX_REG_DATA_H = 4'h5;
    localparam logic [3:0] FX_REG_ID     = 4'h6;

    localparam int FX_STAT_EMPTY = 0;
    localparam int FX_STAT_FULL  = 1;
    localparam int FX_STAT_OVF   = 2;

    localparam int FX_CTRL_EN    = 0;
    localparam int FX_CTRL_FLUSH = 1;

endpackage

// File: rtl/fx_fifo_sp.sv
// Show-ahead single-clock FIFO: dout always presents the head word.
// Push is ignored when full, pop when empty; flush wins over both.
module fx_fifo_sp #(
    parameter int DW    = 16,
    parameter int DEPTH = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  logic           flush,
    input  logic [DW-1:0]  din,
    output logic [DW-1:0]  dout,
    output logic [$clog2(DEPTH):0] count,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign w_push = push & ~full & ~flush;
    assign w_pop  = pop & ~empty & ~flush;

    assign count = r_count;
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks the fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fx_ad_fifo.sv
// FX-bus slave for one AD channel: address decode, CTRL, sticky overflow,
// DATA_H shadow byte and the registered read-data mux. fx_q idles at 8'h00
// so several slaves can be OR-combined on the read bus.
module fx_ad_fifo
    import fx_ad_fifo_pkg::*;
#(
    parameter logic [3:0] BASE   = 4'h1,
    parameter logic [7:0] DEV_ID = 8'hA1,
    parameter int         DEPTH  = 1024
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [7:0]  fx_a,
    input  logic        fx_wr,
    input  logic [7:0]  fx_d,
    input  logic        fx_rd,
    output logic [7:0]  fx_q,
    input  logic [15:0] ad_data,
    input  logic        ad_vld,
    output logic        ad_empty
);
    localparam int AW = $clog2(DEPTH);

    logic        r_en;
    logic        r_ovf;
    logic [7:0]  r_shadow;
    logic [7:0]  r_q;

    logic        w_sel;
    logic        w_rd;
    logic        w_ctrl_wr;
    logic        w_flush;
    logic        w_en_next;
    logic        w_push_req;
    logic        w_ovf_set;
    logic        w_pop;
    logic        w_stat_rd;
    logic        w_datal_rd;
    logic [15:0] w_dout;
    logic [AW:0] w_count;
    logic [15:0] w_cnt16;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_rdata;
    logic        w_unused_d;

    assign w_sel      = (fx_a[7:4] == BASE);
    assign w_rd       = fx_rd & w_sel;
    assign w_ctrl_wr  = fx_wr & w_sel & (fx_a[3:0] == FX_REG_CTRL);
    assign w_flush    = w_ctrl_wr & fx_d[FX_CTRL_FLUSH];
    assign w_en_next  = w_ctrl_wr ? fx_d[FX_CTRL_EN] : r_en;
    assign w_push_req = r_en & ad_vld;
    assign w_ovf_set  = w_push_req & w_full;
    assign w_stat_rd  = w_rd & (fx_a[3:0] == FX_REG_STATUS);
    assign w_datal_rd = w_rd & (fx_a[3:0] == FX_REG_DATA_L);
    assign w_pop      = w_datal_rd & ~w_empty;
    assign w_cnt16    = 16'(w_count);
    assign w_unused_d = ^fx_d[7:2];

    fx_fifo_sp #(
        .DW    (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .push  (w_push_req),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (ad_data),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Read-data mux; a CTRL read in the same cycle as a CTRL write sees the new en.
    always_comb begin
        w_rdata = 8'h00;
        case (fx_a[3:0])
            FX_REG_CTRL:   w_rdata = {7'b0, w_en_next};
            FX_REG_STATUS: w_rdata = {5'b0, r_ovf, w_full, w_empty};
            FX_REG_CNT_L:  w_rdata = w_cnt16[7:0];
            FX_REG_CNT_H:  w_rdata = w_cnt16[15:8];
            FX_REG_DATA_L: w_rdata = w_empty ? 8'h00 : w_dout[7:0];
            FX_REG_DATA_H: w_rdata = r_shadow;
            FX_REG_ID:     w_rdata = DEV_ID;
            default:       w_rdata = 8'h00;
        endcase
    end

    // Capture enable register; flush is a pulse and never stored.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= 1'b0;
        end else begin
            r_en <= w_en_next;
        end
    end

    // Sticky overflow: a new drop outranks the clear-on-read.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_flush) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_stat_rd) begin
            r_ovf <= 1'b0;
        end
    end

    // Shadow captures the head word's high byte on every DATA_L read.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= 8'h00;
        end else if (w_flush) begin
            r_shadow <= 8'h00;
        end else if (w_datal_rd) begin
            r_shadow <= w_empty ? 8'h00 : w_dout[15:8];
        end
    end

    // Read data is held for exactly one cycle after a selected read.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 8'h00;
        end else if (w_rd) begin
            r_q <= w_rdata;
        end else begin
            r_q <= 8'h00;
        end
    end

    assign fx_q     = r_q;
    assign ad_empty = w_empty;

endmodule

// File: tb/tb_fx_ad_fifo.sv
// Scoreboard bench for fx_ad_fifo with DEPTH=8 so wrap and full are quick to reach.
module tb_fx_ad_fifo;
    localparam int DEPTH = 8;

    logic        clk_sys;
    logic        rst_n;
    logic [7:0]  fx_a;
    logic        fx_wr;
    logic [7:0]  fx_d;
    logic        fx_rd;
    logic [7:0]  fx_q;
    logic [15:0] ad_data;
    logic        ad_vld;
    logic        ad_empty;

    int          checks;
    int          errors;
    logic [7:0]  exp_q[$];
    logic        tb_rd_expect;
    logic        mon_pending;

    fx_ad_fifo #(
        .BASE   (4'h1),
        .DEV_ID (8'hA1),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .fx_a     (fx_a),
        .fx_wr    (fx_wr),
        .fx_d     (fx_d),
        .fx_rd    (fx_rd),
        .fx_q     (fx_q),
        .ad_data  (ad_data),
        .ad_vld   (ad_vld),
        .ad_empty (ad_empty)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", name, act, exp);
        end else begin
            $display("ok   %s = %02h", name, act);
        end
    endtask

    // Monitor: one cycle after a read strobe the DUT must show the queued value,
    // on every other cycle fx_q must be idle at zero.
    always @(posedge clk_sys) mon_pending <= tb_rd_expect;

    always @(negedge clk_sys) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (mon_pending) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow got %02h expected none", fx_q);
            end else begin
                check8("rd_data", fx_q, exp_q.pop_front());
            end
        end else if (fx_q !== 8'h00) begin
            checks++;
            errors++;
            $display("FAIL idle_q got %02h expected 00", fx_q);
        end
    end

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp);
        fx_a = addr;
        fx_rd = 1'b1;
        tb_rd_expect = 1'b1;
        exp_q.push_back(exp);
        cyc();
        fx_rd = 1'b0;
        tb_rd_expect = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] d);
        fx_a = addr;
        fx_d = d;
        fx_wr = 1'b1;
        cyc();
        fx_wr = 1'b0;
    endtask

    task automatic push_s(input logic [15:0] d);
        ad_data = d;
        ad_vld = 1'b1;
        cyc();
        ad_vld = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tb_rd_expect = 1'b0;
        fx_a = 8'h00; fx_wr = 1'b0; fx_d = 8'h00; fx_rd = 1'b0;
        ad_data = 16'h0000; ad_vld = 1'b0;
        rst_n = 1'b0;
        #23;
        check8("reset_q", fx_q, 8'h00);
        check8("reset_empty", {7'b0, ad_empty}, 8'h01);
        rst_n = 1'b1;
        cyc();

        // ID and STATUS after reset
        rd(8'h16, 8'hA1);
        cyc();
        rd(8'h11, 8'h01);
        cyc();

        // Basic capture and two-byte reads
        wr(8'h10, 8'h01);
        push_s(16'h1234);
        push_s(16'hABCD);
        rd(8'h12, 8'h02);
        rd(8'h14, 8'h34);
        rd(8'h15, 8'h12);
        rd(8'h14, 8'hCD);
        rd(8'h15, 8'hAB);
        rd(8'h12, 8'h00);
        check8("empty_after_drain", {7'b0, ad_empty}, 8'h01);

        // Overfill: last three samples dropped, ovf sticky then cleared by read
        for (int i = 0; i < DEPTH + 3; i++) push_s(16'h5A00 | 16'(i));
        rd(8'h11, 8'h06);
        rd(8'h11, 8'h02);
        rd(8'h12, 8'(DEPTH));
        rd(8'h13, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            rd(8'h14, 8'(i));
            rd(8'h15, 8'h5A);
        end
        rd(8'h11, 8'h01);

        // Simultaneous push and pop across pointer wrap
        for (int k = 0; k < 5; k++) push_s(16'h2000 + 16'(k));
        for (int j = 0; j < 10; j++) begin
            ad_data = 16'h2005 + 16'(j);
            ad_vld = 1'b1;
            rd(8'h14, 8'h00 + 8'(j));
            ad_vld = 1'b0;
        end
        rd(8'h12, 8'h05);

        // Fill to full, force an overflow, then flush with en kept
        for (int k = 0; k < 4; k++) push_s(16'h7700);
        wr(8'h10, 8'h03);
        rd(8'h12, 8'h00);
        check8("empty_after_flush", {7'b0, ad_empty}, 8'h01);
        rd(8'h10, 8'h01);
        rd(8'h15, 8'h00);
        rd(8'h14, 8'h00);
        rd(8'h11, 8'h01);
        push_s(16'h3344);
        rd(8'h12, 8'h01);
        rd(8'h14, 8'h44);
        rd(8'h15, 8'h33);

        // Other-device accesses are ignored
        rd(8'h26, 8'h00);
        rd(8'h24, 8'h00);
        wr(8'h20, 8'h00);
        push_s(16'h0102);
        rd(8'h12, 8'h01);

        // Asynchronous reset mid-fill while read data is on the bus
        ad_data = 16'h0909;
        ad_vld = 1'b1;
        rd(8'h16, 8'hA1);
        #2;
        rst_n = 1'b0;
        #1;
        check8("async_rst_q", fx_q, 8'h00);
        check8("async_rst_empty", {7'b0, ad_empty}, 8'h01);
        ad_vld = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        rd(8'h10, 8'h00);
        rd(8'h11, 8'h01);
        rd(8'h12, 8'h00);
        rd(8'h15, 8'h00);
        cyc();
        cyc();

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
